// File: rtl/rca32_pkg.sv
// Shared definitions for the 32-bit ripple-carry adder.
// The optional signed-overflow output is enabled by defining RCA32_OVERFLOW_EN.
package rca32_pkg;

  localparam int RCA_WIDTH = 32;

  typedef logic [RCA_WIDTH-1:0] word_t;

  localparam word_t WORD_ZERO = '0;

endpackage

// File: rtl/rca_full_adder.sv
// One-bit full adder cell. It is the building block of the carry chain.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic prop;

  // The propagate term is shared by the sum bit and the carry-out.
  assign prop = a ^ b;
  assign s    = prop ^ ci;
  assign co   = (a & b) | (ci & prop);

endmodule

// File: rtl/rca32_adder.sv
// 32-bit ripple-carry adder with registered sum/cout/out_valid.
// Define RCA32_OVERFLOW_EN to add the registered signed-overflow output ovf.
module rca32_adder
  import rca32_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RCA32_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
  function automatic logic ovf_detect(input logic c_msb_in, input logic c_msb_out);
    return c_msb_in ^ c_msb_out;
  endfunction

  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;

  assign carry_p0[0] = cin;

  // ---- stage p0: combinational ripple chain ----
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    rca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_p0[i]),
      .s  (sum_p0[i]),
      .co (carry_p0[i+1])
    );
  end

  // ---- stage p1: output registers ----
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             vld_p1;

  // Capture the chain result only on valid input, so idle operands never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1  <= WORD_ZERO;
      cout_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= sum_p0;
        cout_p1 <= carry_p0[WIDTH];
      end
    end
  end

`ifdef RCA32_OVERFLOW_EN
  logic ovf_p1;

  // The overflow flag is registered alongside the sum and follows the same hold rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      ovf_p1 <= ovf_detect(carry_p0[WIDTH-1], carry_p0[WIDTH]);
    end
  end

  assign ovf = ovf_p1;
`endif

  assign sum       = sum_p1;
  assign cout      = cout_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_rca32_adder.sv
// Directed and random checks for rca32_adder.
module tb_rca32_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  logic        out_valid;
`ifdef RCA32_OVERFLOW_EN
  logic        ovf;
`endif

  int checks;
  int errors;

  rca32_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
`ifdef RCA32_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one input set on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic v, input logic [31:0] ta,
                      input logic [31:0] tb, input logic tc);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] es, input logic ec,
                            input logic ev);
    check({tag, ".sum"}, {32'd0, sum}, {32'd0, es});
    check({tag, ".cout"}, {63'd0, cout}, {63'd0, ec});
    check({tag, ".vld"}, {63'd0, out_valid}, {63'd0, ev});
  endtask

  logic [31:0] small_a [6] = '{32'd1, 32'd5, 32'd20, 32'd4, 32'd54, 32'd70};
  logic [31:0] small_b [6] = '{32'd2, 32'd7, 32'd20, 32'd1, 32'd10, 32'd2};
  logic [31:0] small_s [6] = '{32'd3, 32'd12, 32'd40, 32'd5, 32'd64, 32'd72};

  initial begin
    logic [32:0] ref_res;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Reset wins over in_valid for two cycles.
    step(1'b1, 1'b1, 32'd5, 32'd7, 1'b0);
    expect_out("rst0", 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd5, 32'd7, 1'b0);
    expect_out("rst1", 32'd0, 1'b0, 1'b0);
`ifdef RCA32_OVERFLOW_EN
    check("rst.ovf", {63'd0, ovf}, 64'd0);
`endif
    step(1'b0, 1'b1, 32'd5, 32'd7, 1'b0);
    expect_out("post_rst", 32'd12, 1'b0, 1'b1);

    // Back-to-back small operands.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, small_a[i], small_b[i], 1'b0);
      expect_out($sformatf("small%0d", i), small_s[i], 1'b0, 1'b1);
    end

    // Carry-in.
    step(1'b0, 1'b1, 32'h0000000F, 32'h00000000, 1'b1);
    expect_out("cin", 32'h00000010, 1'b0, 1'b1);

    // Full-length ripple.
    step(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    expect_out("wrap1", 32'h00000000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    expect_out("wrap2", 32'hFFFFFFFF, 1'b1, 1'b1);
`ifdef RCA32_OVERFLOW_EN
    check("wrap2.ovf", {63'd0, ovf}, 64'd0);
`endif

    // Hold while idle.
    step(1'b0, 1'b1, 32'd20, 32'd20, 1'b0);
    expect_out("hold_load", 32'd40, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'hxxxxxxxx, 32'hxxxxxxxx, 1'bx);
    expect_out("hold_x", 32'd40, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    expect_out("hold_ones", 32'd40, 1'b0, 1'b0);

`ifdef RCA32_OVERFLOW_EN
    step(1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    expect_out("ovf_pos", 32'h80000000, 1'b0, 1'b1);
    check("ovf_pos.ovf", {63'd0, ovf}, 64'd1);
    step(1'b0, 1'b0, 32'd1, 32'd2, 1'b0);
    check("ovf_hold.ovf", {63'd0, ovf}, 64'd1);
    step(1'b0, 1'b1, 32'h80000000, 32'h80000000, 1'b0);
    expect_out("ovf_neg", 32'h00000000, 1'b1, 1'b1);
    check("ovf_neg.ovf", {63'd0, ovf}, 64'd1);
    step(1'b0, 1'b1, 32'd1, 32'd2, 1'b0);
    check("ovf_clr.ovf", {63'd0, ovf}, 64'd0);
`endif

    // Reset mid-stream discards the pending result.
    step(1'b0, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
    expect_out("pre_mid", 32'hFFFFFFFF, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'd3, 32'd4, 1'b0);
    expect_out("mid_rst", 32'd0, 1'b0, 1'b0);
`ifdef RCA32_OVERFLOW_EN
    check("mid_rst.ovf", {63'd0, ovf}, 64'd0);
`endif

    // Random vectors against a 33-bit reference add.
    for (int i = 0; i < 10000; i++) begin
      ra      = $urandom;
      rb      = $urandom;
      rc      = 1'($urandom_range(0, 1));
      ref_res = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      step(1'b0, 1'b1, ra, rb, rc);
      expect_out("rand", ref_res[31:0], ref_res[32], 1'b1);
`ifdef RCA32_OVERFLOW_EN
      check("rand.ovf", {63'd0, ovf},
            {63'd0, (ra[31] == rb[31]) && (ref_res[31] != ra[31])});
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca32_adder.md
Name: rca32_adder

Overview:
- 32-bit ripple-carry adder with registered outputs: sum = a + b + cin, plus carry-out.
- Built as a chain of 32 one-bit full adders; the combinational result is captured on the clock edge.
- Serves as the integer add datapath primitive for the 32-bit MIPS core (ALU add path, PC increment).

Parameters:
- WIDTH, 32, operand/sum bit width. Fixed at 32 for this block; other values are not supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands on a/b/cin are valid this cycle
- a  input  32  operand A, unsigned/two's-complement agnostic
- b  input  32  operand B
- cin  input  1  carry into bit 0
- sum  output  32  registered result bits [31:0]
- cout  output  1  registered carry out of bit 31
- out_valid  output  1  sum/cout hold a result computed from a valid input

Behaviour:
- Reset:
  - On a rising clk edge with rst=1: sum=0, cout=0, out_valid=0.
  - rst takes priority over in_valid in the same cycle.
- Datapath:
  - Bit i: s[i] = a[i]^b[i]^c[i], c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])), with c[0]=cin.
  - The combinational 33-bit result {c[32], s[31:0]} equals a + b + cin exactly.
- Latency:
  - When in_valid=1 at edge N (rst=0), sum/cout/out_valid=1 are visible after edge N.
  - Latency is one cycle; throughput is one result per cycle with no stall.
- Hold: when in_valid=0 (rst=0), sum and cout hold their previous values and out_valid goes to 0 on that edge.
- Wrap-around:
  - The sum is modulo 2^32; cout carries the 2^32 bit.
  - 0xFFFFFFFF + 0 + 1 gives sum=0, cout=1.
- X-propagation: inputs are not sampled while in_valid=0. Undefined operands in that state must not corrupt the held outputs.
- Reset mid-stream: a result pending from the previous edge is discarded, and outputs return to their reset values.
- No backpressure: the consumer must accept a result in the cycle out_valid=1.

Optional Feature:
- Macro: RCA32_OVERFLOW_EN.
- Defined:
  - Adds an output port `ovf` (1 bit), registered with sum.
  - ovf = c[32] ^ c[31], i.e. signed two's-complement overflow.
  - ovf resets to 0 and holds its value when in_valid=0.
- Undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package rca32_pkg holds:
  - localparam RCA_WIDTH = 32;
  - typedef logic [RCA_WIDTH-1:0] word_t;
  - the reset-value constant WORD_ZERO.
- One sub-module is natural: rca_full_adder (inputs a, b, ci; outputs s, co).
  - It is instantiated 32 times via generate, and the carry chain is threaded explicitly.
  - Do not use the behavioural `+` operator for the chain.
- The top level contains only the generate chain, the output registers and the optional overflow logic.

Test Plan:
- Reset then idle: assert rst for 2 cycles with in_valid=1, a=5, b=7 -> sum=0, cout=0, out_valid=0. After rst drops, the next edge gives sum=12.
- Small operands, cin=0, back-to-back one per cycle: (1,2), (5,7), (20,20), (4,1), (54,10), (70,2) -> sums 3, 12, 40, 5, 64, 72 on consecutive cycles. cout=0 and out_valid=1 each cycle.
- Carry-in: a=0x0000000F, b=0x00000000, cin=1 -> sum=0x00000010, cout=0.
- Full wrap: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0, cout=1. Also a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1. This exercises the full-length carry ripple.
- Hold/valid: result 40 latched, then in_valid=0 with a=b=X -> sum stays 40 and out_valid=0. With RCA32_OVERFLOW_EN, a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1, cout=0.
- Random: 10k random a/b/cin vectors, compared against a 33-bit reference add, with one-cycle delay alignment.
